// File: rtl/pid_scheduler.sv
// pid_scheduler: time-multiplexes one external PID arithmetic unit across
// NCH motor channels. A free-running sample-period counter triggers a sweep.
// Each enabled channel gets its error and history issued over a start/done
// handshake. Its integral and previous error are written back, and the
// returned output is clamped into its PWM register.
module pid_scheduler #(
    parameter int NCH      = 4,
    parameter int W        = 8,
    parameter int TICK_DIV = 50000,
    parameter int TIMEOUT  = 64,
    parameter int ILIM     = 2000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH*W-1:0] setpoint,
    input  logic [NCH*W-1:0] speed,
    input  logic [NCH-1:0]   enable,
    output logic             pid_start,
    output logic [2:0]       pid_ch,
    output logic [W:0]       pid_err,
    output logic [W:0]       pid_err_prev,
    output logic [15:0]      pid_integ,
    input  logic             pid_done,
    input  logic [15:0]      pid_out,
    output logic [NCH*W-1:0] pwm,
    output logic             busy,
    output logic [NCH-1:0]   fault,
    output logic             overrun
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WCW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;

    localparam logic signed [16:0] ILIM_POS = 17'(ILIM);
    localparam logic signed [16:0] ILIM_NEG = 17'(-ILIM);
    localparam logic [15:0]        PWM_MAX  = 16'((1 << W) - 1);

    logic [NCH-1:0][W-1:0] sp_a;
    logic [NCH-1:0][W-1:0] spd_a;
    logic [NCH-1:0][W-1:0] pwm_q;
    logic [NCH-1:0][15:0]  integ_q;
    logic [NCH-1:0][W:0]   prev_q;

    logic [2:0]        state;
    logic [CHW-1:0]    ch;
    logic [TCW-1:0]    tick_cnt;
    logic              tick;
    logic [WCW-1:0]    wait_cnt;
    logic [15:0]       out_q;

    logic [W:0]         err_c;
    logic signed [16:0] integ_sum;
    logic [15:0]        integ_sat;
    logic [W-1:0]       pwm_c;

    assign sp_a      = setpoint;
    assign spd_a     = speed;
    assign pwm       = pwm_q;
    assign tick      = (tick_cnt == TCW'(TICK_DIV - 1));
    assign pid_start = (state == S_ISSUE);

    // Error, saturated integral and clamped PWM for the channel being processed.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        err_c     = {1'b0, sp_a[ch]} - {1'b0, spd_a[ch]};
        integ_sum = $signed({integ_q[ch][15], integ_q[ch]}) + 17'($signed(err_c));
        integ_sat = integ_sum[15:0];
        if (integ_sum > ILIM_POS) begin
            integ_sat = ILIM_POS[15:0];
        end else if (integ_sum < ILIM_NEG) begin
            integ_sat = ILIM_NEG[15:0];
        end

        pwm_c = out_q[W-1:0];
        if (out_q[15]) begin
            pwm_c = '0;
        end else if (out_q > PWM_MAX) begin
            pwm_c = '1;
        end
    end

    // Sample-period counter: free-running, wraps at TICK_DIV-1 regardless of state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TCW'(1);
        end
    end

    // Sweep sequencer: walks channels, drives the handshake, writes back state.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: per-channel history arrays are small flop banks, not RAM, so they
        // take the async reset like any other register.
        if (reset) begin
            state        <= S_IDLE;
            ch           <= '0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            fault        <= '0;
            wait_cnt     <= '0;
            out_q        <= '0;
            pwm_q        <= '0;
            integ_q      <= '0;
            prev_q       <= '0;
            pid_ch       <= '0;
            pid_err      <= '0;
            pid_err_prev <= '0;
            pid_integ    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            if (tick && busy) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (tick) begin
                        ch    <= '0;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (!enable[ch]) begin
                        pwm_q[ch]   <= '0;
                        integ_q[ch] <= '0;
                        prev_q[ch]  <= '0;
                        state       <= S_NEXT;
                    end else begin
                        // Operand registers double as the latched err/integ_new.
                        pid_ch       <= 3'(ch);
                        pid_err      <= err_c;
                        pid_err_prev <= prev_q[ch];
                        pid_integ    <= integ_sat;
                        state        <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (pid_done) begin
                        out_q <= pid_out;
                        state <= S_WRITE;
                    end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                        fault[ch] <= 1'b1;
                        pwm_q[ch] <= '0;
                        state     <= S_NEXT;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end

                S_WRITE: begin
                    pwm_q[ch]   <= pwm_c;
                    integ_q[ch] <= pid_integ;
                    prev_q[ch]  <= pid_err;
                    state       <= S_NEXT;
                end

                S_NEXT: begin
                    if (ch == CHW'(NCH - 1)) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        ch    <= ch + CHW'(1);
                        state <= S_LOAD;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_scheduler.sv
// Self-checking bench for pid_scheduler: a behavioural PID-unit responder, a
// sweep-level reference model, a directed vector table, hand-written corner
// sequences (integral saturation, reset mid-WAIT) and randomized sweeps.
module tb_pid_scheduler;

    localparam int NCH      = 4;
    localparam int W        = 8;
    localparam int TICK_DIV = 70;
    localparam int TIMEOUT  = 16;
    localparam int ILIM     = 2000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NCH*W-1:0] setpoint = '0;
    logic [NCH*W-1:0] speed = '0;
    logic [NCH-1:0]   enable = '0;
    logic             pid_start;
    logic [2:0]       pid_ch;
    logic [W:0]       pid_err;
    logic [W:0]       pid_err_prev;
    logic [15:0]      pid_integ;
    logic             pid_done = 1'b0;
    logic [15:0]      pid_out = '0;
    logic [NCH*W-1:0] pwm;
    logic             busy;
    logic [NCH-1:0]   fault;
    logic             overrun;

    pid_scheduler #(
        .NCH(NCH), .W(W), .TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT), .ILIM(ILIM)
    ) dut (
        .clk(clk), .reset(reset), .setpoint(setpoint), .speed(speed),
        .enable(enable), .pid_start(pid_start), .pid_ch(pid_ch),
        .pid_err(pid_err), .pid_err_prev(pid_err_prev), .pid_integ(pid_integ),
        .pid_done(pid_done), .pid_out(pid_out), .pwm(pwm), .busy(busy),
        .fault(fault), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // PID-unit responder configuration: answers lat cycles after the start
    // pulse with k*err+off, except for channels in noans.
    int             lat = 5;
    int             k = 3;
    int             off = 0;
    logic [NCH-1:0] noans = '0;

    int          cyc = 0;
    logic        pend = 1'b0;
    int          due = 0;
    logic [15:0] resp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pid_done = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend && cyc == due) begin
                pid_done = 1'b1;
                pid_out  = resp;
                pend     = 1'b0;
            end
            if (pid_start === 1'b1 && !noans[pid_ch]) begin
                pend = 1'b1;
                due  = cyc + lat;
                resp = 16'(k * int'($signed(pid_err)) + off);
            end
        end
    end

    typedef struct {
        int ch;
        int err;
        int prev;
        int integ;
    } issue_t;

    issue_t issued_q[$];

    always @(negedge clk) begin
        if (pid_start === 1'b1) begin
            issued_q.push_back('{int'(pid_ch), int'($signed(pid_err)),
                                 int'($signed(pid_err_prev)), int'($signed(pid_integ))});
        end
    end

    // Reference model state, one entry per channel.
    int             integ_m[NCH];
    int             prev_m[NCH];
    int             pwm_m[NCH];
    logic [NCH-1:0] fault_m;
    logic           ovr_m;

    task automatic clear_model();
        for (int c = 0; c < NCH; c++) begin
            integ_m[c] = 0;
            prev_m[c]  = 0;
            pwm_m[c]   = 0;
        end
        fault_m = '0;
        ovr_m   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Predict one whole sweep, wait for it to run, then compare operands,
    // sweep length and resulting PWM / fault / overrun.
    task automatic do_sweep(input string tag);
        issue_t exp_q[$];
        int exp_len, len, n, err, ni, o, cnt;
        exp_len = 0;
        for (int c = 0; c < NCH; c++) begin
            if (!enable[c]) begin
                integ_m[c] = 0;
                prev_m[c]  = 0;
                pwm_m[c]   = 0;
                exp_len   += 2;
            end else begin
                err = int'(setpoint[c*W +: W]) - int'(speed[c*W +: W]);
                ni  = integ_m[c] + err;
                if (ni > ILIM) ni = ILIM;
                else if (ni < -ILIM) ni = -ILIM;
                exp_q.push_back('{c, err, prev_m[c], ni});
                if (noans[c] || lat > TIMEOUT) begin
                    fault_m[c] = 1'b1;
                    pwm_m[c]   = 0;
                    exp_len   += 3 + TIMEOUT;
                end else begin
                    o          = k * err + off;
                    pwm_m[c]   = (o < 0) ? 0 : (o > (1 << W) - 1) ? (1 << W) - 1 : o;
                    integ_m[c] = ni;
                    prev_m[c]  = err;
                    exp_len   += 4 + lat;
                end
            end
        end
        if (exp_len >= TICK_DIV) ovr_m = 1'b1;

        issued_q.delete();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b1 && n < 3 * TICK_DIV);
        check({tag, "_busy_rise"}, busy, 1);

        len = 0;
        while (busy === 1'b1 && len < 4 * TICK_DIV) begin
            len++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, len, exp_len);

        check({tag, "_n_issue"}, issued_q.size(), exp_q.size());
        cnt = (issued_q.size() < exp_q.size()) ? issued_q.size() : exp_q.size();
        for (int i = 0; i < cnt; i++) begin
            check({tag, "_ch"},    issued_q[i].ch,    exp_q[i].ch);
            check({tag, "_err"},   issued_q[i].err,   exp_q[i].err);
            check({tag, "_prev"},  issued_q[i].prev,  exp_q[i].prev);
            check({tag, "_integ"}, issued_q[i].integ, exp_q[i].integ);
        end
        for (int c = 0; c < NCH; c++) begin
            check({tag, "_pwm"}, pwm[c*W +: W], pwm_m[c]);
        end
        check({tag, "_fault"},   fault,   fault_m);
        check({tag, "_overrun"}, overrun, ovr_m);
    endtask

    typedef struct {
        logic [W-1:0]     sp;
        logic [W-1:0]     spd;
        logic [NCH-1:0]   en;
        int               lat;
        int               k;
        int               off;
        logic [NCH-1:0]   na;
        logic [NCH*W-1:0] e_pwm;
        logic [NCH-1:0]   e_fault;
        logic             e_ovr;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'd100, 8'd60, 4'hF,  5, 3,   0, 4'h0, 32'h78787878, 4'h0, 1'b0};
        tbl[1] = '{8'd100, 8'd60, 4'hF,  5, 0, -10, 4'h0, 32'h00000000, 4'h0, 1'b0};
        tbl[2] = '{8'd100, 8'd60, 4'hF,  5, 0, 400, 4'h0, 32'hFFFFFFFF, 4'h0, 1'b0};
        tbl[3] = '{8'd100, 8'd60, 4'hA,  5, 3,   0, 4'h0, 32'h78007800, 4'h0, 1'b0};
        tbl[4] = '{8'd100, 8'd60, 4'hF,  5, 3,   0, 4'h0, 32'h78787878, 4'h0, 1'b0};
        tbl[5] = '{8'd100, 8'd60, 4'hF,  5, 3,   0, 4'h4, 32'h78007878, 4'h4, 1'b0};
        tbl[6] = '{8'd100, 8'd60, 4'hF,  5, 3,   0, 4'h0, 32'h78787878, 4'h4, 1'b0};
        tbl[7] = '{8'd100, 8'd60, 4'hF, 16, 3,   0, 4'h0, 32'h78787878, 4'h4, 1'b1};
        tbl[8] = '{8'd100, 8'd60, 4'hF, 17, 3,   0, 4'h0, 32'h00000000, 4'hF, 1'b1};

        clear_model();

        // Asynchronous reset with no clock edge yet.
        #1 reset = 1'b1;
        #2;
        check("rst_busy",      busy,      0);
        check("rst_pwm",       pwm,       0);
        check("rst_fault",     fault,     0);
        check("rst_overrun",   overrun,   0);
        check("rst_pid_start", pid_start, 0);
        check("rst_pid_integ", pid_integ, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            setpoint = {NCH{tbl[i].sp}};
            speed    = {NCH{tbl[i].spd}};
            enable   = tbl[i].en;
            lat      = tbl[i].lat;
            k        = tbl[i].k;
            off      = tbl[i].off;
            noans    = tbl[i].na;
            do_sweep($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_pwm_vec", i),   pwm,     tbl[i].e_pwm);
            check($sformatf("tbl%0d_fault_vec", i), fault,   tbl[i].e_fault);
            check($sformatf("tbl%0d_ovr_vec", i),   overrun, tbl[i].e_ovr);
            if (i == 0 && issued_q.size() > 0) begin
                check("first_integ", issued_q[0].integ, 40);
            end
            if (i == 1 && issued_q.size() > 0) begin
                check("second_prev",  issued_q[0].prev,  40);
                check("second_integ", issued_q[0].integ, 80);
            end
            if (i == 4 && issued_q.size() > 0) begin
                check("reenable_integ", issued_q[0].integ, 40);
            end
        end

        // Integral saturation with err=+255 held over ten sweeps.
        do_reset();
        setpoint = {NCH{8'd255}};
        speed    = '0;
        enable   = '1;
        lat      = 2;
        k        = 0;
        off      = 0;
        noans    = '0;
        for (int n = 1; n <= 10; n++) begin
            do_sweep($sformatf("sat%0d", n));
            if (issued_q.size() > 0) begin
                check($sformatf("sat%0d_integ", n), issued_q[0].integ,
                      (255 * n > ILIM) ? ILIM : 255 * n);
            end
        end

        // Randomized sweeps against the reference model.
        for (int r = 0; r < 30; r++) begin
            int sel;
            for (int c = 0; c < NCH; c++) begin
                setpoint[c*W +: W] = W'($urandom_range(0, 255));
                speed[c*W +: W]    = W'($urandom_range(0, 255));
            end
            enable = NCH'($urandom_range(0, 15));
            lat    = $urandom_range(1, 6);
            k      = $urandom_range(0, 6) - 2;
            off    = $urandom_range(0, 600) - 300;
            sel    = $urandom_range(0, 5);
            noans  = (sel < NCH) ? NCH'(1 << sel) : '0;
            do_sweep($sformatf("rnd%0d", r));
        end

        // Reset asserted while the scheduler waits on an unanswered channel.
        begin
            int n;
            setpoint = {NCH{8'd100}};
            speed    = {NCH{8'd60}};
            enable   = '1;
            lat      = 5;
            k        = 3;
            off      = 0;
            noans    = '1;
            n = 0;
            while (pid_start !== 1'b1 && n < 3 * TICK_DIV) begin
                @(negedge clk);
                n++;
            end
            check("mw_start_seen", pid_start, 1);
            repeat (3) @(negedge clk);
            #2 reset = 1'b1;
            #1;
            check("mw_busy",      busy,         0);
            check("mw_pwm",       pwm,          0);
            check("mw_fault",     fault,        0);
            check("mw_overrun",   overrun,      0);
            check("mw_pid_start", pid_start,    0);
            check("mw_pid_err",   pid_err,      0);
            check("mw_pid_prev",  pid_err_prev, 0);
            check("mw_pid_integ", pid_integ,    0);
            check("mw_pid_ch",    pid_ch,       0);
            clear_model();
            @(negedge clk);
            reset = 1'b0;
            noans = '0;
            do_sweep("post_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
